// File: rtl/apb_pkg.sv
// Shared definitions for the round-robin APB master: FSM state encoding
// and default parameter values.
package apb_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'b00;
  localparam apb_state_t ST_SETUP  = 2'b01;
  localparam apb_state_t ST_ACCESS = 2'b10;

  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int DEPTH_DEF   = 32;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// The result is a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  // Scan NREQ slots from ptr with wrap-around; the first asserted request wins
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters through a round-robin arbiter.
// It runs one IDLE/SETUP/ACCESS transfer at a time and returns a one-cycle
// response pulse to the requester that owns the transfer. An access can end
// on a wait-state timeout. An out-of-range address is rejected without
// starting a bus cycle.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [AW-1:0]      paddr,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
  output logic               psel,
  output logic               penable,
  input  logic               pready,
  input  logic               pslverr,
  input  logic [DW-1:0]      prdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  apb_state_t      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_wait;
  logic [AW-1:0]   r_paddr;
  logic            r_pwrite;
  logic [DW-1:0]   r_pwdata;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;

  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_others;
  logic [NREQ-1:0] w_arb_req;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_grant_idx;
  logic [IW-1:0]   w_next_ptr;
  logic            w_any;
  logic            w_done;
  logic [AW-1:0]   w_win_addr;
  logic            w_win_write;
  logic [DW-1:0]   w_win_wdata;
  logic            w_win_bad;

  assign w_owner_oh = NREQ'(1) << r_owner;
  assign w_others   = req_valid & ~w_owner_oh;
  assign w_done     = (r_state == ST_ACCESS) && pready;

  // Arbitrate while idle. At completion, arbitrate again but skip the owner,
  // because it still holds its request until it sees its response.
  always_comb begin
    w_arb_req = '0;
    if (r_state == ST_IDLE) begin
      w_arb_req = req_valid;
    end else if (w_done) begin
      w_arb_req = (w_others != '0) ? w_others : req_valid;
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (w_arb_req),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_any       = |w_arb_req;
  assign w_win_addr  = req_addr[w_grant_idx*AW +: AW];
  assign w_win_write = req_write[w_grant_idx];
  assign w_win_wdata = req_wdata[w_grant_idx*DW +: DW];
  assign w_win_bad   = (w_win_addr >= DEPTH_A);
  assign w_next_ptr  = (w_grant_idx == IW'(NREQ - 1)) ? '0 : IW'(w_grant_idx + 1'b1);

  // FSM, transfer capture, wait counter and one-cycle response pulse
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_wait      <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ptr <= w_next_ptr;
            if (w_win_bad) begin
              r_rsp_valid <= w_grant;
              r_rsp_err   <= 1'b1;
            end else begin
              r_owner  <= w_grant_idx;
              r_paddr  <= w_win_addr;
              r_pwrite <= w_win_write;
              r_pwdata <= w_win_wdata;
              r_state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_wait  <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            r_wait      <= '0;
            r_rsp_valid <= w_owner_oh;
            r_rsp_err   <= pslverr;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            // A bad-address winner is left for IDLE to reject, so the error
            // pulse cannot coincide with this completion pulse.
            if (w_any && !w_win_bad) begin
              r_ptr    <= w_next_ptr;
              r_owner  <= w_grant_idx;
              r_paddr  <= w_win_addr;
              r_pwrite <= w_win_write;
              r_pwdata <= w_win_wdata;
              r_state  <= ST_SETUP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_wait      <= '0;
            r_rsp_valid <= w_owner_oh;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wait <= CW'(r_wait + 1'b1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable   = (r_state == ST_ACCESS);
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: reset-time contention, a table of single
// transfers, and reset asserted in the middle of an ACCESS cycle.
module tb_apb_rr_master;

  localparam int NREQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 16;

  logic               pclk;
  logic               prst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [AW-1:0]      paddr;
  logic               pwrite;
  logic [DW-1:0]      pwdata;
  logic               psel;
  logic               penable;
  logic               pready;
  logic               pslverr;
  logic [DW-1:0]      prdata;

  int n_checks = 0;
  int n_fail = 0;

  apb_rr_master #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(32), .TIMEOUT(TMO)
  ) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // Slave read data is a fixed function of the address
  assign prdata = 32'hC0DE_0000 + paddr;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int          req;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          slverr;
    bit          tmo;
    bit          bad;
    bit          noise;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic set_req(input int r, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_valid[r] = 1'b1;
    req_write[r] = w;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [NREQ-1:0] oh;
    int n_acc;
    oh = '0;
    oh[v.req] = 1'b1;
    req_valid = '0;
    set_req(v.req, v.write, v.addr, v.wdata);
    pready = 1'b0;
    pslverr = 1'b0;
    check("idle_psel", i, psel, 0);
    @(negedge pclk);
    req_valid = '0;
    if (v.bad) begin
      check("bad_psel", i, psel, 0);
      check("bad_rsp_valid", i, rsp_valid, oh);
      check("bad_rsp_err", i, rsp_err, 1);
      check("bad_rsp_rdata", i, rsp_rdata, 0);
      @(negedge pclk);
      check("bad_psel2", i, psel, 0);
      check("bad_rsp_clear", i, rsp_valid, 0);
      return;
    end
    check("setup_psel", i, psel, 1);
    check("setup_penable", i, penable, 0);
    check("setup_paddr", i, paddr, v.addr);
    check("setup_pwrite", i, pwrite, v.write);
    if (v.write) check("setup_pwdata", i, pwdata, v.wdata);
    if (v.noise) begin
      pready = 1'b1;
      pslverr = 1'b1;
    end
    n_acc = v.tmo ? TMO : v.waits + 1;
    for (int c = 0; c < n_acc; c++) begin
      @(negedge pclk);
      check("acc_penable", i, {psel, penable}, 2'b11);
      check("acc_paddr", i, paddr, v.addr);
      if (v.write) check("acc_pwdata", i, pwdata, v.wdata);
      check("acc_no_rsp", i, rsp_valid, 0);
      pready = !v.tmo && (c == v.waits);
      pslverr = pready && v.slverr;
    end
    @(negedge pclk);
    pready = 1'b0;
    pslverr = 1'b0;
    check("rsp_valid", i, rsp_valid, oh);
    check("rsp_err", i, rsp_err, v.exp_err);
    check("rsp_rdata", i, rsp_rdata, v.exp_rdata);
    check("rsp_psel_idle", i, psel, 0);
    @(negedge pclk);
    check("rsp_single_pulse", i, rsp_valid, 0);
  endtask

  initial begin
    int o;
    int po;
    logic [NREQ-1:0] oh;
    // req write addr wdata waits slverr tmo bad noise exp_rdata exp_err
    vt[0] = '{0, 1'b1, 32'd5,  32'hA5A5_0001, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vt[1] = '{2, 1'b0, 32'd7,  32'h0,         0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0007, 1'b0};
    vt[2] = '{1, 1'b1, 32'd12, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vt[3] = '{3, 1'b0, 32'd31, 32'h0,         1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC0DE_001F, 1'b1};
    vt[4] = '{3, 1'b0, 32'd0,  32'h0,         2, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0000, 1'b0};
    vt[5] = '{1, 1'b0, 32'd9,  32'h0,         0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0009, 1'b0};
    vt[6] = '{0, 1'b0, 32'd3,  32'h0,         0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1};
    vt[7] = '{2, 1'b1, 32'd32, 32'hFFFF_0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1};

    // Reset with all four requesters already reading their own address 4*i+1
    prst = 1'b0;
    pready = 1'b1;
    pslverr = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 32'(4 * r + 1), 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    check("rst_psel", 0, psel, 0);
    check("rst_penable", 0, penable, 0);
    check("rst_rsp_valid", 0, rsp_valid, 0);
    check("rst_rsp_rdata", 0, rsp_rdata, 0);
    check("rst_rsp_err", 0, rsp_err, 0);
    check("rst_paddr", 0, paddr, 0);
    check("rst_pwdata", 0, pwdata, 0);
    check("rst_pwrite", 0, pwrite, 0);
    prst = 1'b1;

    // Continuous contention: grants 0,1,2,3,0 back to back with no IDLE
    for (int g = 0; g < 5; g++) begin
      o = g % NREQ;
      @(negedge pclk);
      check("cont_setup", g, {psel, penable}, 2'b10);
      check("cont_paddr", g, paddr, 32'(4 * o + 1));
      if (g > 0) begin
        po = (g - 1) % NREQ;
        oh = '0;
        oh[po] = 1'b1;
        check("cont_rsp_valid", g, rsp_valid, oh);
        check("cont_rsp_rdata", g, rsp_rdata, 32'hC0DE_0000 + 32'(4 * po + 1));
        check("cont_rsp_err", g, rsp_err, 0);
      end
      @(negedge pclk);
      check("cont_access", g, {psel, penable}, 2'b11);
      check("cont_rsp_gap", g, rsp_valid, 0);
      if (g == 4) req_valid = '0;
    end
    @(negedge pclk);
    pready = 1'b0;
    check("cont_last_rsp", 5, rsp_valid, 4'b0001);
    check("cont_last_rdata", 5, rsp_rdata, 32'hC0DE_0001);
    check("cont_idle", 5, psel, 0);
    @(negedge pclk);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vt[i]);
      @(negedge pclk);
    end

    // Reset in the middle of an ACCESS cycle
    req_valid = '0;
    set_req(1, 1'b0, 32'd4, 32'h0);
    pready = 1'b0;
    @(negedge pclk);
    req_valid = '0;
    check("mid_setup", 0, {psel, penable}, 2'b10);
    @(negedge pclk);
    check("mid_access", 0, {psel, penable}, 2'b11);
    #2;
    prst = 1'b0;
    #1;
    check("mid_async_drop", 0, {psel, penable}, 2'b00);
    check("mid_async_paddr", 0, paddr, 0);
    for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 32'(4 * r + 1), 32'h0);
    @(negedge pclk);
    check("mid_rst_no_rsp", 0, rsp_valid, 0);
    @(negedge pclk);
    check("mid_rst_no_rsp", 1, rsp_valid, 0);
    prst = 1'b1;
    @(negedge pclk);
    check("post_rst_setup", 0, psel, 1);
    check("post_rst_winner", 0, paddr, 32'd1);
    check("post_rst_no_rsp", 0, rsp_valid, 0);
    req_valid = '0;
    pready = 1'b1;
    @(negedge pclk);
    check("post_rst_access", 0, penable, 1);
    @(negedge pclk);
    pready = 1'b0;
    check("post_rst_rsp", 0, rsp_valid, 4'b0001);
    check("post_rst_rdata", 0, rsp_rdata, 32'hC0DE_0001);
    @(negedge pclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
